uart_rx: RTL
============

Name: uart_rx

Overview:
- UART 8N1 receiver, LSB-first, idle-high line; the receive-side counterpart of the board's TX path.
- Bit period is CLKS_PER_BIT cycles of CLKIN, default 16, matching the transmitter's baud tick.
- Synchronises RX, qualifies the start bit at mid-bit and samples data and stop at bit centres.
- Delivers each byte through a one-deep valid/ready output register; framing and overrun errors are reported as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16: CLKIN cycles per serial bit; must be even and >= 4. HALF = CLKS_PER_BIT/2.

Ports:
- CLKIN  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- RX  input  1  serial line, asynchronous to CLKIN; idle high.
- READY  input  1  consumer accepts DATA when VALID and READY are both high at a rising edge.
- DATA  output  8  received byte; held stable while VALID=1.
- VALID  output  1  DATA holds an unconsumed byte.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  output  1  one-cycle pulse: good byte completed while the output register was still full; the new byte is dropped.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Asynchronous, active-high; clock: CLKIN.
  - DATA=0x00; VALID, FRAME_ERR, OVERRUN and BUSY =0.
  - State = IDLE; bit counter and clock counter = 0.
  - Both synchroniser flops reset to 1, so no false start comes out of reset.
- Synchroniser: 2-flop; rx_s is RX delayed 2 cycles. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - The first cycle with rx_s=0 is cycle D.
  - Go to START and clear the clock counter.
- START:
  - At D+HALF, sample rx_s.
  - rx_s=1: false start; return to IDLE with no output activity.
  - rx_s=0: go to DATA with bit index 0.
- DATA:
  - Bit i (0..7) is sampled at D+HALF+(i+1)*CLKS_PER_BIT into shift position i (LSB first).
  - After bit 7, go to STOP.
- STOP: sample rx_s at D+HALF+9*CLKS_PER_BIT.
  - rx_s=1, VALID=0 (or VALID=1 with READY=1 in that same cycle): next cycle DATA=byte, VALID=1; go to IDLE.
  - rx_s=1, VALID=1, READY=0: next cycle OVERRUN=1 for one cycle; DATA and VALID unchanged; go to IDLE.
  - rx_s=0: next cycle FRAME_ERR=1 for one cycle; byte discarded; go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. No start detection while in BREAK.
- Output handshake:
  - VALID and READY both high at an edge clears VALID next cycle, unless a new byte loads in that same cycle (then VALID stays 1 with the new DATA).
  - DATA never changes while VALID=1 except through that load.
- Latency: RX falling edge at pin cycle E gives D=E+2 and VALID at E+3+HALF+9*CLKS_PER_BIT (E+155 for 16).
- Back-to-back frames: returning to IDLE at mid-stop lets a start bit that immediately follows the stop bit be detected.
- Edge cases:
  - Glitches shorter than HALF cycles are rejected.
  - BUSY is high from D+1 through the stop-sample cycle, and during BREAK.
  - Reset mid-frame aborts immediately; any partial byte is lost.

Test Plan:
- 0x68 ('h') frame, 16 clk/bit, READY=1 -> VALID one cycle at E+155 with DATA=0x68; FRAME_ERR=OVERRUN=0.
- "hello world\r\n" sent back-to-back (no idle between frames), READY=1 -> 13 VALID pulses, bytes in order, each exactly 160 cycles apart.
- RX low for 4 cycles, then high -> no VALID and no errors; BUSY pulses, then IDLE; a following 0x55 frame is received correctly.
- 0xA5 frame with stop bit driven 0 and RX held low 50 cycles -> FRAME_ERR one pulse at E+155, no VALID; the next frame is detected only after RX returns high.
- READY=0; send 0x01 then 0x02 -> DATA=0x01 with VALID held; OVERRUN pulse at the end of frame 2; raising READY then drops VALID, DATA stays 0x01.
- RESET asserted mid-data bits of 0x3C, then released -> all outputs at reset values immediately; the next 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
//
// The RX pin goes through a two-flop synchroniser. A low level on the
// synchronised line is qualified at mid-bit and treated as a start bit.
// The eight data bits and the stop bit are then sampled at their bit
// centres. A good byte goes to a one-deep valid/ready output register.
// A low stop bit sends the receiver to BREAK, and it stays there until the
// line returns high.
//
// Parameters:
//   CLKS_PER_BIT  CLKIN cycles per serial bit (even, >= 4)
//
// Ports:
//   CLKIN      in   system clock, rising-edge active
//   RESET      in   asynchronous, active-high reset
//   RX         in   serial line, asynchronous to CLKIN, idle high
//   READY      in   consumer takes DATA when VALID & READY at an edge
//   DATA       out  received byte, stable while VALID is high
//   VALID      out  DATA holds an unconsumed byte
//   FRAME_ERR  out  one-cycle pulse: stop bit sampled low
//   OVERRUN    out  one-cycle pulse: good byte dropped, output register full
//   BUSY       out  receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLKIN,
    input  logic       RESET,
    input  logic       RX,
    input  logic       READY,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state;
    logic             rx_p0;
    logic             rx_p1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign rx_s = rx_p1;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            // The synchroniser resets to the idle level, so the receiver
            // does not see a false start when it leaves reset.
            rx_p0     <= 1'b1;
            rx_p1     <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            // synchroniser stage boundary: rx_p0 -> rx_p1 (rx_s)
            rx_p0 <= RX;
            rx_p1 <= rx_p0;

            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;

            // The consumer's handshake clears VALID. A byte loaded in the
            // STOP branch below overrides this clear, because it is a later
            // assignment in the same block.
            if (VALID && READY) begin
                VALID <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end

                ST_START: begin
                    // Check the start bit again at mid-bit. This rejects
                    // glitches that are shorter than half a bit.
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    // The receiver goes back to IDLE at mid-stop. This lets
                    // it catch a start bit that directly follows the stop bit.
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            if (!VALID || READY) begin
                                DATA  <= shreg;
                                VALID <= 1'b1;
                            end else begin
                                OVERRUN <= 1'b1;
                            end
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
